disp_scan_sched: RTL and testbench

Scan scheduler and source arbiter for the four-digit, active-low seven-segment display. It time-multiplexes the anodes with a programmable dwell and an anti-ghosting blank gap. It arbitrates between the running score (4-digit BCD) and short status messages requested by the game FSM. It double-buffers the score so that content changes only at frame boundaries.

---
 rtl/disp_scan_sched.sv | 92 +++++++++
 tb/tb_disp_scan_sched.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/disp_scan_sched.sv
// disp_scan_sched: four-digit seven-segment scan with score/message arbitration and frame-aligned updates
module disp_scan_sched #(
  parameter int DWELL = 4,
  parameter int BLANK = 1,
  parameter int MSG_FRAMES = 8
) (
  input  logic        segclk,
  input  logic        clr,
  input  logic [15:0] score_bcd,
  input  logic        score_vld,
  input  logic        lz_blank,
  input  logic        msg_req,
  input  logic [1:0]  msg_code,
  output logic        msg_ack,
  output logic        msg_busy,
  output logic        frame_tick,
  output logic [6:0]  seg,
  output logic [3:0]  an
);
  localparam int CW = $clog2((DWELL > BLANK ? DWELL : BLANK) + 1);
  localparam int FW = $clog2(MSG_FRAMES + 1);
  localparam logic [6:0] DGLY [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000,
    7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111
  };
  localparam logic [6:0] MGLY [16] = '{
    7'b1000010, 7'b1000000, 7'b1111111, 7'b1111111,
    7'b0000110, 7'b0101011, 7'b0100001, 7'b1111111,
    7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111,
    7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000
  };
  typedef enum logic {LIT, GAP} phase_t;
  phase_t          ph, ph_n;
  logic [1:0]      dig, dig_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [15:0]     shadow, active;
  logic [1:0]      code;
  logic [FW-1:0]   mcnt;
  logic            last, commit, lz;
  logic [3:0]      nib;
  logic [6:0]      glyph;
  always_ff @(posedge segclk or posedge clr)
    if (clr) begin
      ph  <= LIT;
      dig <= '0;
      cnt <= '0;
    end else begin
      ph  <= ph_n;
      dig <= dig_n;
      cnt <= cnt_n;
    end
  always_comb begin
    last   = cnt == CW'(ph == LIT ? DWELL - 1 : BLANK - 1);
    commit = ph == GAP && dig == 2'd3 && cnt == '0;
    cnt_n  = last ? '0 : cnt + CW'(1);
    ph_n   = last ? (ph == LIT ? GAP : LIT) : ph;
    dig_n  = last && ph == GAP ? dig + 2'd1 : dig;
    nib    = active[{~dig, 2'b00} +: 4];
    lz     = lz_blank && dig != 2'd3 && (active >> {~dig, 2'b00}) == 16'd0;
    glyph  = msg_busy ? MGLY[{code, dig}] : lz ? 7'h7f : DGLY[nib];
  end
  always_ff @(posedge segclk or posedge clr)
    if (clr) begin
      shadow     <= '0;
      active     <= '0;
      code       <= '0;
      mcnt       <= '0;
      msg_busy   <= 1'b0;
      msg_ack    <= 1'b0;
      frame_tick <= 1'b0;
      seg        <= 7'h7f;
      an         <= 4'hf;
    end else begin
      seg        <= ph == LIT ? glyph : 7'h7f;
      an         <= ph == LIT ? ~(4'b1000 >> dig) : 4'hf;
      frame_tick <= commit;
      msg_ack    <= commit && !msg_busy && msg_req;
      if (score_vld) shadow <= score_bcd;
      if (commit) begin
        active <= score_vld ? score_bcd : shadow;
        if (!msg_busy && msg_req) begin
          msg_busy <= 1'b1;
          code     <= msg_code;
          mcnt     <= '0;
        end else if (msg_busy) begin
          if (mcnt == FW'(MSG_FRAMES - 1)) msg_busy <= 1'b0;
          mcnt <= mcnt + FW'(1);
        end
      end
    end
endmodule

// File: tb/tb_disp_scan_sched.sv
// tb_disp_scan_sched: directed and randomized checks of the scan scheduler against a frame-level model
module tb_disp_scan_sched;
  localparam int DW = 4, BL = 1, MF = 8, PER = DW + BL, FRM = 4 * PER;
  logic        segclk = 0, clr = 0;
  logic [15:0] score_bcd = 0;
  logic        score_vld = 0, lz_blank = 0, msg_req = 0;
  logic [1:0]  msg_code = 0;
  logic        msg_ack, msg_busy, frame_tick;
  logic [6:0]  seg;
  logic [3:0]  an;
  int n_checks = 0, n_fail = 0;
  int n = 0, m_frames = 0, pos, slot;
  bit commit, m_busy = 0;
  logic [15:0] m_shadow = 0, m_active = 0;
  logic [1:0]  m_code = 0;
  logic [6:0]  e_seg = 7'h7f;
  logic [3:0]  e_an = 4'hf;
  logic        e_ack = 0, e_busy = 0, e_tick = 0;
  string msgs [4] = '{"GO  ", "End ", "----", "8888"};

  disp_scan_sched #(.DWELL(DW), .BLANK(BL), .MSG_FRAMES(MF)) dut (
    .segclk(segclk), .clr(clr), .score_bcd(score_bcd), .score_vld(score_vld),
    .lz_blank(lz_blank), .msg_req(msg_req), .msg_code(msg_code), .msg_ack(msg_ack),
    .msg_busy(msg_busy), .frame_tick(frame_tick), .seg(seg), .an(an)
  );

  always #5 segclk = ~segclk;

  function automatic logic [6:0] digit_glyph(int v);
    case (v)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  function automatic logic [6:0] char_glyph(byte c);
    case (c)
      "G": return 7'b1000010;
      "O": return 7'b1000000;
      "E": return 7'b0000110;
      "n": return 7'b0101011;
      "d": return 7'b0100001;
      "-": return 7'b0111111;
      "8": return 7'b0000000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [6:0] score_glyph(logic [15:0] v, int s, logic lz);
    int nib [4];
    bit lead = 1;
    for (int i = 0; i < 4; i++) nib[i] = int'((v >> (12 - 4 * i)) & 16'hf);
    for (int i = 0; i <= s; i++) lead = lead && nib[i] == 0;
    if (lz && s < 3 && lead) return 7'h7f;
    return digit_glyph(nib[s]);
  endfunction

  // Frame-level reference: position within the frame is derived purely from the edge count.
  initial forever begin
    @(posedge segclk or posedge clr);
    if (clr) begin
      n = 0; m_shadow = 0; m_active = 0; m_busy = 0; m_frames = 0; m_code = 0;
      e_seg = 7'h7f; e_an = 4'hf; e_ack = 0; e_busy = 0; e_tick = 0;
    end else begin
      n++;
      pos = (n - 1) % FRM;
      slot = pos / PER;
      commit = n % FRM == 0;
      e_an = 4'hf;
      e_seg = 7'h7f;
      if (pos % PER < DW) begin
        e_an[3 - slot] = 1'b0;
        e_seg = m_busy ? char_glyph(msgs[m_code][slot]) : score_glyph(m_active, slot, lz_blank);
      end
      e_tick = commit;
      e_ack = 0;
      if (score_vld) m_shadow = score_bcd;
      if (commit) begin
        m_active = m_shadow;
        if (m_busy) begin
          m_frames--;
          if (m_frames == 0) m_busy = 0;
        end else if (msg_req) begin
          m_busy = 1; m_frames = MF; m_code = msg_code; e_ack = 1;
        end
      end
      e_busy = m_busy;
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %b expected %b", name, n, act, exp);
    end
  endtask

  task automatic lit(input string name, input logic [15:0] dv, input logic [15:0] mv, input logic [15:0] exp);
    chk(name, dv, exp);
    chk({name, "_model"}, mv, exp);
  endtask

  task automatic wait_edge(input int k);
    while (n < k) @(negedge segclk);
  endtask

  task automatic pulse_clr();
    @(negedge segclk);
    clr = 1;
    #1;
    chk("clr_an", 16'(an), 16'hf);
    chk("clr_seg", 16'(seg), 16'h7f);
    chk("clr_busy", 16'(msg_busy), 0);
    chk("clr_tick", 16'(frame_tick), 0);
    @(negedge segclk);
    clr = 0;
  endtask

  initial forever begin
    @(posedge segclk);
    #2;
    chk("seg", 16'(seg), 16'(e_seg));
    chk("an", 16'(an), 16'(e_an));
    chk("ack", 16'(msg_ack), 16'(e_ack));
    chk("busy", 16'(msg_busy), 16'(e_busy));
    chk("tick", 16'(frame_tick), 16'(e_tick));
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at edge %0d", n);
    $fatal(1, "watchdog");
  end

  initial begin
    #1 clr = 1;
    @(negedge segclk);
    @(negedge segclk);
    chk("rst_seg", 16'(seg), 16'h7f);
    chk("rst_an", 16'(an), 16'hf);
    chk("rst_ack", 16'(msg_ack), 0);
    clr = 0;
    wait_edge(1);  lit("e1_an", 16'(an), 16'(e_an), 16'b0111);
    lit("e1_seg", 16'(seg), 16'(e_seg), 16'b1000000);
    wait_edge(5);  lit("e5_gap", 16'(an), 16'(e_an), 16'hf);
    score_bcd = 16'h0042; score_vld = 1;
    wait_edge(6);  lit("e6_an", 16'(an), 16'(e_an), 16'b1011);
    wait_edge(7);  score_vld = 0;
    wait_edge(13); lit("e13_old", 16'(seg), 16'(e_seg), 16'b1000000);
    wait_edge(16); lz_blank = 1;
    wait_edge(20); lit("e20_tick", 16'(frame_tick), 16'(e_tick), 1);
    wait_edge(21); lit("e21_blank", 16'(seg), 16'(e_seg), 16'h7f);
    wait_edge(31); lit("e31_d2", 16'(seg), 16'(e_seg), 16'b0011001);
    wait_edge(36); lit("e36_d3", 16'(seg), 16'(e_seg), 16'b0100100);
    wait_edge(39); score_bcd = 16'h1234; score_vld = 1;
    wait_edge(40); score_vld = 0;
    wait_edge(41); lit("e41_bypass", 16'(seg), 16'(e_seg), 16'b1111001);
    wait_edge(46); lit("e46_d1", 16'(seg), 16'(e_seg), 16'b0100100);
    wait_edge(50); lz_blank = 0;
    pulse_clr();
    wait_edge(2);  msg_req = 1; msg_code = 1;
    wait_edge(20); lit("acc_ack", 16'(msg_ack), 16'(e_ack), 1);
    lit("acc_busy", 16'(msg_busy), 16'(e_busy), 1);
    wait_edge(21); lit("msg_E", 16'(seg), 16'(e_seg), 16'b0000110);
    wait_edge(40); lit("no_reack", 16'(msg_ack), 16'(e_ack), 0);
    wait_edge(100); msg_code = 3; score_bcd = 16'h0A00; score_vld = 1;
    wait_edge(101); score_vld = 0;
    lit("code_ignored", 16'(seg), 16'(e_seg), 16'b0000110);
    wait_edge(180); lit("retire_busy", 16'(msg_busy), 16'(e_busy), 0);
    lit("retire_ack", 16'(msg_ack), 16'(e_ack), 0);
    wait_edge(186); lit("nibA_dash", 16'(seg), 16'(e_seg), 16'b0111111);
    wait_edge(200); lit("reacc_ack", 16'(msg_ack), 16'(e_ack), 1);
    msg_req = 0;
    wait_edge(201); lit("lamp", 16'(seg), 16'(e_seg), 16'b0000000);
    wait_edge(250);
    pulse_clr();
    wait_edge(1);  lit("post_clr_an", 16'(an), 16'(e_an), 16'b0111);
    lit("post_clr_seg", 16'(seg), 16'(e_seg), 16'b1000000);
    for (int i = 0; i < 4000; i++) begin
      @(negedge segclk);
      clr = 0;
      score_vld = $urandom_range(7) == 0;
      if (score_vld) score_bcd = 16'($urandom);
      if ($urandom_range(63) == 0) lz_blank = !lz_blank;
      if ($urandom_range(39) == 0) begin
        msg_req = !msg_req;
        msg_code = 2'($urandom);
      end
      if ($urandom_range(799) == 0) clr = 1;
    end
    @(negedge segclk);
    clr = 0;
    repeat (3) @(negedge segclk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
